// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the I2C transaction sequencer: FSM encoding,
// engine config-word layout and byte-count decoding.
package i2c_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOAD_N,
      ST_LOAD_A,
      ST_FILL_A,
      ST_FILL_B,
      ST_EXEC,
      ST_BUSY,
      ST_DONE,
      ST_ERR
   } seq_state_t;

   localparam int CFG_NB_MSB = 7;
   localparam int CFG_NB_LSB = 4;
   localparam int CFG_RD_BIT = 3;

   localparam bit NB_ZERO_MEANS_16 = 1'b1;

   function automatic logic [7:0] cfg_word(input logic [3:0] nb, input logic rd);
      logic [7:0] w;
      w = '0;
      w[CFG_NB_MSB:CFG_NB_LSB] = nb;
      w[CFG_RD_BIT]            = rd;
      return w;
   endfunction

   function automatic logic [4:0] nb_count(input logic [3:0] nb);
      if (nb == 4'd0 && NB_ZERO_MEANS_16) return 5'd16;
      return {1'b0, nb};
   endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Engine-side bus between the transaction sequencer (master) and the
// I2C master engine (slave).
interface i2c_txn_sequencer_if;

   logic       DEV_SEL;
   logic       LOAD_N_BYTE;
   logic       LOAD_ADDR;
   logic       WRT_ENA;
   logic       EXECUTE;
   logic [3:0] WRT_ADDR;
   logic [7:0] WRT_DATA;
   logic       I2C_READY;
   logic       RBK_WE;
   logic [7:0] RBK_DATA;

   modport master (
      output DEV_SEL, LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, EXECUTE, WRT_ADDR, WRT_DATA,
      input  I2C_READY, RBK_WE, RBK_DATA
   );

   modport slave (
      input  DEV_SEL, LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, EXECUTE, WRT_ADDR, WRT_DATA,
      output I2C_READY, RBK_WE, RBK_DATA
   );

endinterface

// File: rtl/i2c_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant from the request
// levels and a pointer that flips to the other requester on each advance.
module i2c_rr_arb
   import i2c_ctrl_pkg::*;
(
   input  logic       CLK40,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       adv,
   input  logic       served1,
   output logic [1:0] gnt
);

   logic ptr_q, ptr_d;

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

   always_comb begin
      ptr_d = ptr_q;
      // ptr = 1 favours REQ1, i.e. REQ0 was served last
      if (adv) ptr_d = ~served1;

      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Round-robin arbiter and transaction sequencer in front of the I2C engine.
// Define I2C_RBK_CHK_EN to turn readback byte-count mismatches into ERR.
module i2c_txn_sequencer
   import i2c_ctrl_pkg::*;
#(
   parameter int TMO_W  = 20,
   parameter int N_SYNC = 2
) (
   input  logic       CLK40,
   input  logic       RST,
   input  logic [1:0] REQ,
   input  logic [7:0] RQ_ADDR0,
   input  logic [7:0] RQ_ADDR1,
   input  logic [3:0] RQ_NB0,
   input  logic [3:0] RQ_NB1,
   input  logic [1:0] RQ_RD,
   input  logic [7:0] RQ_WD0,
   input  logic [7:0] RQ_WD1,
   output logic [1:0] GNT,
   output logic [3:0] WIDX,
   output logic       WSTB,
   output logic [7:0] RDATA,
   output logic [1:0] RVALID,
   output logic [1:0] DONE,
   output logic [1:0] ERR,
   i2c_txn_sequencer_if.master eng
);

   seq_state_t        state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [7:0]        addr_q, addr_d;
   logic [3:0]        nb_q, nb_d;
   logic              rd_q, rd_d;
   logic [3:0]        idx_q, idx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [N_SYNC-1:0] sync_q, sync_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [1:0]        rvalid_q, rvalid_d;
`ifdef I2C_RBK_CHK_EN
   logic [4:0]        rcnt_q, rcnt_d;
`endif

   logic       ready_s;
   logic       arb_adv;
   logic [1:0] arb_gnt;
   logic [3:0] last_idx;
   logic       tmo_hit;

   assign ready_s  = sync_q[N_SYNC-1];
   assign last_idx = 4'(nb_count(nb_q) - 5'd1);
   assign tmo_hit  = (tmo_q == {TMO_W{1'b1}});

   i2c_rr_arb u_arb (
      .CLK40   (CLK40),
      .RST     (RST),
      .req     (REQ),
      .adv     (arb_adv),
      .served1 (gnt_q[1]),
      .gnt     (arb_gnt)
   );

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         addr_q   <= '0;
         nb_q     <= '0;
         rd_q     <= 1'b0;
         idx_q    <= '0;
         tmo_q    <= '0;
         sync_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
`ifdef I2C_RBK_CHK_EN
         rcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         addr_q   <= addr_d;
         nb_q     <= nb_d;
         rd_q     <= rd_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         sync_q   <= sync_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
`ifdef I2C_RBK_CHK_EN
         rcnt_q   <= rcnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      addr_d   = addr_q;
      nb_d     = nb_q;
      rd_d     = rd_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      sync_d   = {sync_q[N_SYNC-2:0], eng.I2C_READY};
      rdata_d  = rdata_q;
      rvalid_d = '0;
      arb_adv  = 1'b0;
`ifdef I2C_RBK_CHK_EN
      rcnt_d   = rcnt_q;
`endif

      eng.DEV_SEL     = 1'b0;
      eng.LOAD_N_BYTE = 1'b0;
      eng.LOAD_ADDR   = 1'b0;
      eng.WRT_ENA     = 1'b0;
      eng.EXECUTE     = 1'b0;
      eng.WRT_ADDR    = '0;
      eng.WRT_DATA    = '0;
      WIDX            = '0;
      WSTB            = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (REQ != 2'b00 && ready_s) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (arb_gnt != 2'b00) begin
               gnt_d   = arb_gnt;
               addr_d  = arb_gnt[1] ? RQ_ADDR1 : RQ_ADDR0;
               nb_d    = arb_gnt[1] ? RQ_NB1   : RQ_NB0;
               rd_d    = arb_gnt[1] ? RQ_RD[1] : RQ_RD[0];
               idx_d   = '0;
`ifdef I2C_RBK_CHK_EN
               rcnt_d  = '0;
`endif
               state_d = ST_LOAD_N;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_N: begin
            eng.DEV_SEL     = 1'b1;
            eng.LOAD_N_BYTE = 1'b1;
            eng.WRT_DATA    = cfg_word(nb_q, rd_q);
            state_d         = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            eng.DEV_SEL   = 1'b1;
            eng.LOAD_ADDR = 1'b1;
            eng.WRT_DATA  = addr_q;
            if (rd_q) begin
               tmo_d   = '0;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FILL_A;
            end
         end
         ST_FILL_A: begin
            WIDX    = idx_q;
            state_d = ST_FILL_B;
         end
         ST_FILL_B: begin
            // requester has had a full cycle to present the byte for idx_q
            WIDX         = idx_q;
            WSTB         = 1'b1;
            eng.DEV_SEL  = 1'b1;
            eng.WRT_ENA  = 1'b1;
            eng.WRT_ADDR = idx_q;
            eng.WRT_DATA = gnt_q[1] ? RQ_WD1 : RQ_WD0;
            idx_d        = idx_q + 4'd1;
            if (idx_q == last_idx) begin
               tmo_d   = '0;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FILL_A;
            end
         end
         ST_EXEC: begin
            eng.DEV_SEL = 1'b1;
            eng.EXECUTE = 1'b1;
            if (tmo_hit) begin
               state_d = ST_ERR;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
               if (!ready_s) state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (eng.RBK_WE) begin
               rdata_d  = eng.RBK_DATA;
               rvalid_d = gnt_q;
`ifdef I2C_RBK_CHK_EN
               if (rcnt_q != 5'h1f) rcnt_d = rcnt_q + 5'd1;
`endif
            end
            if (tmo_hit) begin
               state_d = ST_ERR;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
               if (ready_s) begin
`ifdef I2C_RBK_CHK_EN
                  if (rd_q ? (rcnt_d != nb_count(nb_q)) : (rcnt_d != 5'd0))
                     state_d = ST_ERR;
                  else
                     state_d = ST_DONE;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
         ST_DONE, ST_ERR: begin
            gnt_d   = '0;
            arb_adv = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign GNT    = gnt_q;
   assign RDATA  = rdata_q;
   assign RVALID = rvalid_q;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign DONE[gi] = (state_q == ST_DONE) && gnt_q[gi];
         assign ERR[gi]  = (state_q == ST_ERR)  && gnt_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural I2C engine model;
// TMO_W is shrunk so the hung-engine timeout fits in a short run.
module tb_i2c_txn_sequencer;

   localparam int TMO_W = 6;

   logic       CLK40;
   logic       RST;
   logic [1:0] REQ;
   logic [7:0] RQ_ADDR0, RQ_ADDR1;
   logic [3:0] RQ_NB0, RQ_NB1;
   logic [1:0] RQ_RD;
   logic [7:0] RQ_WD0, RQ_WD1;
   logic [1:0] GNT;
   logic [3:0] WIDX;
   logic       WSTB;
   logic [7:0] RDATA;
   logic [1:0] RVALID, DONE, ERR;

   i2c_txn_sequencer_if eng_if ();

   i2c_txn_sequencer #(.TMO_W(TMO_W), .N_SYNC(2)) dut (
      .CLK40    (CLK40),
      .RST      (RST),
      .REQ      (REQ),
      .RQ_ADDR0 (RQ_ADDR0),
      .RQ_ADDR1 (RQ_ADDR1),
      .RQ_NB0   (RQ_NB0),
      .RQ_NB1   (RQ_NB1),
      .RQ_RD    (RQ_RD),
      .RQ_WD0   (RQ_WD0),
      .RQ_WD1   (RQ_WD1),
      .GNT      (GNT),
      .WIDX     (WIDX),
      .WSTB     (WSTB),
      .RDATA    (RDATA),
      .RVALID   (RVALID),
      .DONE     (DONE),
      .ERR      (ERR),
      .eng      (eng_if)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] wd0_tab [16];
   logic [7:0] wd1_tab [16];

   always_comb begin
      RQ_WD0 = wd0_tab[WIDX];
      RQ_WD1 = wd1_tab[WIDX];
   end

   initial CLK40 = 1'b0;
   always #5 CLK40 = ~CLK40;

   // ---------------- engine model ----------------
   bit         eng_hang = 1'b0;
   int         eng_nrbk = 0;
   logic [7:0] eng_rbk [16];

   initial begin
      eng_if.I2C_READY = 1'b1;
      eng_if.RBK_WE    = 1'b0;
      eng_if.RBK_DATA  = 8'h00;
      forever begin
         @(negedge CLK40);
         if (eng_if.EXECUTE && !eng_hang) begin
            repeat (3) @(negedge CLK40);
            eng_if.I2C_READY = 1'b0;
            for (int k = 0; k < 20 && eng_if.EXECUTE; k++) @(negedge CLK40);
            repeat (4) @(negedge CLK40);
            for (int b = 0; b < eng_nrbk; b++) begin
               eng_if.RBK_DATA = eng_rbk[b];
               eng_if.RBK_WE   = 1'b1;
               @(negedge CLK40);
               eng_if.RBK_WE   = 1'b0;
               @(negedge CLK40);
            end
            repeat (3) @(negedge CLK40);
            eng_if.I2C_READY = 1'b1;
         end
      end
   end

   // ---------------- bus monitor ----------------
   int         wr_cnt = 0, wstb_cnt = 0, exec_cycles = 0, rv_n = 0;
   int         rv0_cnt = 0, rv1_cnt = 0, done_cnt = 0, err_cnt = 0, gnt_n = 0;
   logic [3:0] wr_addr_log [128];
   logic [7:0] wr_data_log [128];
   logic [7:0] rv_log [128];
   logic [1:0] gnt_log [16];
   logic [7:0] cfg_seen = 8'hxx, addr_seen = 8'hxx;
   logic [1:0] done_last = 2'b00, err_last = 2'b00, gnt_prev = 2'b00;
   logic       exec_at_err = 1'b0;

   always @(negedge CLK40) begin
      if (eng_if.WRT_ENA) begin
         if (wr_cnt < 128) begin
            wr_addr_log[wr_cnt] <= eng_if.WRT_ADDR;
            wr_data_log[wr_cnt] <= eng_if.WRT_DATA;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (WSTB) wstb_cnt <= wstb_cnt + 1;
      if (eng_if.LOAD_N_BYTE) cfg_seen <= eng_if.WRT_DATA;
      if (eng_if.LOAD_ADDR) addr_seen <= eng_if.WRT_DATA;
      if (eng_if.EXECUTE) exec_cycles <= exec_cycles + 1;
      if (RVALID != 2'b00) begin
         if (rv_n < 128) rv_log[rv_n] <= RDATA;
         rv_n <= rv_n + 1;
      end
      if (RVALID[0]) rv0_cnt <= rv0_cnt + 1;
      if (RVALID[1]) rv1_cnt <= rv1_cnt + 1;
      if (DONE != 2'b00) begin
         done_cnt  <= done_cnt + 1;
         done_last <= DONE;
      end
      if (ERR != 2'b00) begin
         err_cnt     <= err_cnt + 1;
         err_last    <= ERR;
         exec_at_err <= eng_if.EXECUTE;
      end
      if (GNT != 2'b00 && gnt_prev == 2'b00) begin
         if (gnt_n < 16) gnt_log[gnt_n] <= GNT;
         gnt_n <= gnt_n + 1;
      end
      gnt_prev <= GNT;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   // hold REQ[r] until DONE[r] or ERR[r], bounded
   task automatic run_req(input int r, input int budget);
      bit seen;
      seen   = 1'b0;
      REQ[r] = 1'b1;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge CLK40);
         if (DONE[r] || ERR[r]) seen = 1'b1;
      end
      REQ[r] = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL txn_end req%0d: got no DONE/ERR within %0d cycles", r, budget);
      end
      repeat (3) @(negedge CLK40);
      #1;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK40);
      RST = 1'b0;
      repeat (4) @(negedge CLK40);
      #1;
   endtask

   task automatic test_reset();
      logic [47:0] outs;
      RST = 1'b0;
      REQ = 2'b00;
      #2 RST = 1'b1;
      repeat (3) @(negedge CLK40);
      #1;
      outs = {GNT, WIDX, WSTB, RDATA, RVALID, DONE, ERR, eng_if.DEV_SEL, eng_if.LOAD_N_BYTE,
              eng_if.LOAD_ADDR, eng_if.WRT_ENA, eng_if.EXECUTE, eng_if.WRT_ADDR, eng_if.WRT_DATA};
      checks++;
      if (outs !== 48'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      RST = 1'b0;
      repeat (6) @(negedge CLK40);
      #1;
      checks++;
      if (GNT !== 2'b00 || eng_if.DEV_SEL !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: GNT=%b DEV_SEL=%b expected 00/0", GNT, eng_if.DEV_SEL);
      end
      $display("txn reset: outputs=%h", outs);
   endtask

   task automatic test_write();
      int w0, d0, e0, g0, x0, s0;
      RQ_ADDR0 = 8'h12; RQ_NB0 = 4'd2; RQ_RD[0] = 1'b0;
      wd0_tab[0] = 8'hA5; wd0_tab[1] = 8'h5A;
      w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt; g0 = gnt_n; x0 = exec_cycles; s0 = wstb_cnt;
      run_req(0, 300);
      checks++;
      if (cfg_seen !== 8'h20) begin errors++; $display("FAIL wr_cfg: got %h expected 20", cfg_seen); end
      checks++;
      if (addr_seen !== 8'h12) begin errors++; $display("FAIL wr_addr: got %h expected 12", addr_seen); end
      checks++;
      if (wr_cnt - w0 != 2 || wstb_cnt - s0 != 2) begin
         errors++; $display("FAIL wr_count: wrt_ena %0d wstb %0d expected 2/2", wr_cnt - w0, wstb_cnt - s0);
      end
      checks++;
      if (wr_addr_log[w0] !== 4'd0 || wr_data_log[w0] !== 8'hA5) begin
         errors++; $display("FAIL wr_byte0: got %0d/%h expected 0/A5", wr_addr_log[w0], wr_data_log[w0]);
      end
      checks++;
      if (wr_addr_log[w0+1] !== 4'd1 || wr_data_log[w0+1] !== 8'h5A) begin
         errors++; $display("FAIL wr_byte1: got %0d/%h expected 1/5A", wr_addr_log[w0+1], wr_data_log[w0+1]);
      end
      checks++;
      if (exec_cycles - x0 < 2 || exec_cycles - x0 > 12) begin
         errors++; $display("FAIL wr_exec_len: got %0d cycles expected 2..12", exec_cycles - x0);
      end
      checks++;
      if (done_cnt - d0 != 1 || done_last !== 2'b01 || err_cnt != e0) begin
         errors++; $display("FAIL wr_done: done %0d last %b err %0d expected 1/01/0", done_cnt - d0, done_last, err_cnt - e0);
      end
      checks++;
      if (gnt_log[g0] !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b expected 01", gnt_log[g0]); end
      $display("txn write req0: cfg=%h addr=%h bytes=%0d", cfg_seen, addr_seen, wr_cnt - w0);
   endtask

   task automatic test_read();
      int w0, d0, r0, r1, rn;
      RQ_ADDR1 = 8'h40; RQ_NB1 = 4'd3; RQ_RD[1] = 1'b1;
      eng_nrbk = 3; eng_rbk[0] = 8'h11; eng_rbk[1] = 8'h22; eng_rbk[2] = 8'h33;
      w0 = wr_cnt; d0 = done_cnt; r0 = rv0_cnt; r1 = rv1_cnt; rn = rv_n;
      run_req(1, 300);
      eng_nrbk = 0;
      checks++;
      if (cfg_seen !== 8'h38) begin errors++; $display("FAIL rd_cfg: got %h expected 38", cfg_seen); end
      checks++;
      if (addr_seen !== 8'h40) begin errors++; $display("FAIL rd_addr: got %h expected 40", addr_seen); end
      checks++;
      if (wr_cnt != w0) begin errors++; $display("FAIL rd_no_fill: got %0d writes expected 0", wr_cnt - w0); end
      checks++;
      if (rv1_cnt - r1 != 3 || rv0_cnt != r0) begin
         errors++; $display("FAIL rd_rvalid: rv1 %0d rv0 %0d expected 3/0", rv1_cnt - r1, rv0_cnt - r0);
      end
      checks++;
      if (rv_log[rn] !== 8'h11 || rv_log[rn+1] !== 8'h22 || rv_log[rn+2] !== 8'h33) begin
         errors++; $display("FAIL rd_data: got %h %h %h expected 11 22 33", rv_log[rn], rv_log[rn+1], rv_log[rn+2]);
      end
      checks++;
      if (done_cnt - d0 != 1 || done_last !== 2'b10) begin
         errors++; $display("FAIL rd_done: done %0d last %b expected 1/10", done_cnt - d0, done_last);
      end
      $display("txn read req1: cfg=%h addr=%h rbk=%0d", cfg_seen, addr_seen, rv1_cnt - r1);
   endtask

   task automatic test_round_robin();
      int g0, n;
      logic [1:0] exp_seq [4];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
      pulse_reset();
      RQ_NB0 = 4'd1; RQ_RD[0] = 1'b0; RQ_NB1 = 4'd1; RQ_RD[1] = 1'b0;
      g0 = gnt_n; n = 0;
      REQ = 2'b11;
      for (int c = 0; c < 800 && n < 4; c++) begin
         @(negedge CLK40);
         if (DONE != 2'b00) n++;
      end
      REQ = 2'b00;
      repeat (3) @(negedge CLK40);
      #1;
      checks++;
      if (n != 4 || gnt_n - g0 != 4) begin
         errors++; $display("FAIL rr_count: done %0d grants %0d expected 4/4", n, gnt_n - g0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (gnt_log[g0+i] !== exp_seq[i]) begin
            errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, gnt_log[g0+i], exp_seq[i]);
         end
      end
      $display("txn round_robin: grants %b %b %b %b", gnt_log[g0], gnt_log[g0+1], gnt_log[g0+2], gnt_log[g0+3]);
   endtask

   task automatic test_nb16();
      int w0, d0;
      RQ_ADDR0 = 8'h7E; RQ_NB0 = 4'd0; RQ_RD[0] = 1'b0;
      for (int i = 0; i < 16; i++) wd0_tab[i] = 8'(8'hC0 + i);
      w0 = wr_cnt; d0 = done_cnt;
      run_req(0, 400);
      checks++;
      if (cfg_seen !== 8'h00) begin errors++; $display("FAIL nb16_cfg: got %h expected 00", cfg_seen); end
      checks++;
      if (wr_cnt - w0 != 16) begin errors++; $display("FAIL nb16_count: got %0d expected 16", wr_cnt - w0); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wr_addr_log[w0+i] !== 4'(i) || wr_data_log[w0+i] !== 8'(8'hC0 + i)) begin
            errors++;
            $display("FAIL nb16_byte%0d: got %0d/%h expected %0d/%h", i, wr_addr_log[w0+i], wr_data_log[w0+i], i, 8'(8'hC0 + i));
         end
      end
      checks++;
      if (done_cnt - d0 != 1 || done_last !== 2'b01) begin
         errors++; $display("FAIL nb16_done: done %0d last %b expected 1/01", done_cnt - d0, done_last);
      end
      $display("txn nb0 write: bytes=%0d", wr_cnt - w0);
   endtask

   task automatic test_timeout();
      int d0, e0, x0;
      RQ_ADDR1 = 8'h05; RQ_NB1 = 4'd1; RQ_RD[1] = 1'b0; wd1_tab[0] = 8'h99;
      eng_hang = 1'b1;
      d0 = done_cnt; e0 = err_cnt; x0 = exec_cycles;
      run_req(1, 400);
      eng_hang = 1'b0;
      checks++;
      if (err_cnt - e0 != 1 || err_last !== 2'b10 || done_cnt != d0) begin
         errors++; $display("FAIL tmo_err: err %0d last %b done %0d expected 1/10/0", err_cnt - e0, err_last, done_cnt - d0);
      end
      checks++;
      if (exec_cycles - x0 != 64) begin
         errors++; $display("FAIL tmo_len: got %0d EXECUTE cycles expected 64", exec_cycles - x0);
      end
      checks++;
      if (exec_at_err !== 1'b0) begin errors++; $display("FAIL tmo_exec_low: got %b expected 0", exec_at_err); end
      d0 = done_cnt;
      RQ_NB0 = 4'd1; RQ_RD[0] = 1'b0;
      run_req(0, 300);
      checks++;
      if (done_cnt - d0 != 1 || done_last !== 2'b01) begin
         errors++; $display("FAIL tmo_recover: done %0d last %b expected 1/01", done_cnt - d0, done_last);
      end
      $display("txn timeout req1: exec_cycles=%0d then req0 done=%b", exec_cycles - x0, done_last);
   endtask

   task automatic test_reset_mid();
      int w0, d0, c;
      logic [47:0] outs;
      RQ_ADDR0 = 8'h33; RQ_NB0 = 4'd3; RQ_RD[0] = 1'b0;
      w0 = wr_cnt;
      REQ[0] = 1'b1;
      c = 0;
      while (c < 200 && WIDX !== 4'd1) begin
         @(negedge CLK40);
         c++;
      end
      checks++;
      if (WIDX !== 4'd1) begin errors++; $display("FAIL rstmid_reach: WIDX %0d expected 1", WIDX); end
      RST = 1'b1;
      @(posedge CLK40);
      #1;
      outs = {GNT, WIDX, WSTB, RDATA, RVALID, DONE, ERR, eng_if.DEV_SEL, eng_if.LOAD_N_BYTE,
              eng_if.LOAD_ADDR, eng_if.WRT_ENA, eng_if.EXECUTE, eng_if.WRT_ADDR, eng_if.WRT_DATA};
      checks++;
      if (outs !== 48'd0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", outs); end
      REQ = 2'b00;
      @(negedge CLK40);
      RST = 1'b0;
      d0 = done_cnt;
      repeat (30) @(negedge CLK40);
      #1;
      checks++;
      if (done_cnt != d0 || GNT !== 2'b00 || wr_cnt - w0 != 1) begin
         errors++; $display("FAIL rstmid_idle: done %0d GNT %b writes %0d expected 0/00/1", done_cnt - d0, GNT, wr_cnt - w0);
      end
      $display("txn reset_in_fill: outputs=%h writes=%0d", outs, wr_cnt - w0);
   endtask

`ifdef I2C_RBK_CHK_EN
   task automatic test_rbk_check();
      int d0, e0;
      RQ_ADDR1 = 8'h41; RQ_NB1 = 4'd3; RQ_RD[1] = 1'b1;
      eng_nrbk = 2; eng_rbk[0] = 8'hAA; eng_rbk[1] = 8'hBB;
      d0 = done_cnt; e0 = err_cnt;
      run_req(1, 300);
      eng_nrbk = 0;
      checks++;
      if (err_cnt - e0 != 1 || err_last !== 2'b10 || done_cnt != d0) begin
         errors++; $display("FAIL rbkchk_err: err %0d last %b done %0d expected 1/10/0", err_cnt - e0, err_last, done_cnt - d0);
      end
      $display("txn rbk_short read req1: err=%b", err_last);
   endtask
`endif

   initial begin
      RST = 1'b0;
      REQ = 2'b00;
      RQ_ADDR0 = 8'h00; RQ_ADDR1 = 8'h00;
      RQ_NB0 = 4'd0; RQ_NB1 = 4'd0; RQ_RD = 2'b00;
      for (int i = 0; i < 16; i++) begin
         wd0_tab[i] = 8'h00;
         wd1_tab[i] = 8'h00;
         eng_rbk[i] = 8'h00;
      end
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_nb16();
      test_timeout();
      test_reset_mid();
`ifdef I2C_RBK_CHK_EN
      test_rbk_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
